// File: rtl/coeff_pkg.sv
// Shared types and sizing helpers for the double-buffered FIR coefficient store.
package coeff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND
    } coeff_state_e;

    localparam int COEFF_W_DEFAULT  = 8;
    localparam int NUM_TAPS_DEFAULT = 71;

    // Number of words a complete shadow load takes; symmetric loads cover both halves per word.
    function automatic int load_len(input int num_taps, input bit sym);
        return sym ? (num_taps + 1) / 2 : num_taps;
    endfunction

endpackage

// File: rtl/coeff_bank_ram.sv
// One NUM_TAPS x COEFF_W register bank: a single write port with a mirror address and a flat parallel read bus.
module coeff_bank_ram #(
    parameter int NUM_TAPS = 71,
    parameter int COEFF_W  = 8,
    parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [ADDR_W-1:0]             waddr_mirror,
    input  logic [COEFF_W-1:0]            wdata,
    output logic [NUM_TAPS*COEFF_W-1:0]   rdata_flat
);

    logic [COEFF_W-1:0] mem [NUM_TAPS];

    // NOTE: the bank is flop-based, so it is cleared on reset; an idle FIR must see all-zero taps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr]        <= wdata;
            mem[waddr_mirror] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_read
        assign rdata_flat[k*COEFF_W +: COEFF_W] = mem[k];
    end

endmodule

// File: rtl/coeff_bank_dbuf.sv
// Double-buffered coefficient store: streams a shadow bank, swaps it active on a sample boundary.
// Optional build macro COEFF_SYMMETRIC_EN: half-length loads mirrored into both halves of the bank.
module coeff_bank_dbuf
    import coeff_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEFAULT,
    parameter int COEFF_W  = COEFF_W_DEFAULT,
    parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          load_valid,
    input  logic [COEFF_W-1:0]            load_data,
    output logic                          load_ready,
    output logic                          load_done,
    output logic                          load_err,
    input  logic                          swap_req,
    input  logic                          sample_tick,
    output logic                          swap_done,
    output logic                          pending,
    output logic                          bank_sel,
    output logic [NUM_TAPS*COEFF_W-1:0]   coeff_flat
);

`ifdef COEFF_SYMMETRIC_EN
    localparam bit SYM = 1'b1;
`else
    localparam bit SYM = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(load_len(NUM_TAPS, SYM) - 1);

    coeff_state_e            state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr, ptr_d, wr_mirror;
    logic                    accept, swap_fire;
    logic [NUM_TAPS*COEFF_W-1:0] flat0, flat1;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = wr_ptr;
        accept     = 1'b0;
        swap_fire  = 1'b0;
        load_ready = (state_q == LOAD);
        pending    = (state_q == PEND);
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                // A restart takes priority over a coincident handshake, dropping that word.
                if (load_start) begin
                    ptr_d = '0;
                end else if (load_valid) begin
                    accept = 1'b1;
                    if (wr_ptr == LAST) begin
                        state_d = PEND;
                    end else begin
                        ptr_d = wr_ptr + ADDR_W'(1);
                    end
                end
            end
            PEND: begin
                if (swap_req && sample_tick) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end else if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            swap_done <= 1'b0;
            bank_sel  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr    <= ptr_d;
            load_done <= accept && (wr_ptr == LAST);
            load_err  <= load_valid && !load_ready;
            swap_done <= swap_fire;
            if (swap_fire) begin
                bank_sel <= ~bank_sel;
            end
        end
    end

`ifdef COEFF_SYMMETRIC_EN
    assign wr_mirror = ADDR_W'(NUM_TAPS - 1 - int'(wr_ptr));
`else
    assign wr_mirror = wr_ptr;
`endif

    // The shadow bank is always the one not selected, so loads never disturb the live taps.
    coeff_bank_ram #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) u_bank0 (
        .clk          (clk),
        .rst          (rst),
        .we           (accept && bank_sel),
        .waddr        (wr_ptr),
        .waddr_mirror (wr_mirror),
        .wdata        (load_data),
        .rdata_flat   (flat0)
    );

    coeff_bank_ram #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) u_bank1 (
        .clk          (clk),
        .rst          (rst),
        .we           (accept && !bank_sel),
        .waddr        (wr_ptr),
        .waddr_mirror (wr_mirror),
        .wdata        (load_data),
        .rdata_flat   (flat1)
    );

    assign coeff_flat = bank_sel ? flat1 : flat0;

endmodule

// File: tb/tb_coeff_bank_dbuf.sv
// Self-checking bench for coeff_bank_dbuf against an array-level model of the active/shadow taps.
module tb_coeff_bank_dbuf;

    localparam int N = 71;
    localparam int W = 8;
`ifdef COEFF_SYMMETRIC_EN
    localparam bit SYM = 1'b1;
    localparam int LEN = (N + 1) / 2;
`else
    localparam bit SYM = 1'b0;
    localparam int LEN = N;
`endif

    logic             clk = 1'b0;
    logic             rst, load_start, load_valid, swap_req, sample_tick;
    logic [W-1:0]     load_data;
    logic             load_ready, load_done, load_err, swap_done, pending, bank_sel;
    logic [N*W-1:0]   coeff_flat;

    coeff_bank_dbuf #(.NUM_TAPS(N), .COEFF_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_err    (load_err),
        .swap_req    (swap_req),
        .sample_tick (sample_tick),
        .swap_done   (swap_done),
        .pending     (pending),
        .bank_sel    (bank_sel),
        .coeff_flat  (coeff_flat)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] sent     [N];
    logic [W-1:0] act_m    [N];
    logic [W-1:0] shadow_m [N];
    bit           bank_m;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Tap k comes from word k, or from the nearer-end word when loads are mirrored.
    function automatic int word_for_tap(input int k);
        if (SYM) return (k < N - 1 - k) ? k : N - 1 - k;
        return k;
    endfunction

    function automatic int first_bad_tap();
        for (int k = 0; k < N; k++) begin
            if (coeff_flat[k*W +: W] !== act_m[k]) return k;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        swap_req    = 1'b0;
        sample_tick = 1'b0;
    endtask

    // Streams sent[0..nwords-1] after a load_start; a full-length load becomes the pending set.
    task automatic load_words(input int nwords, input bit gaps, input bit junk_on_start);
        int i = 0;
        int budget = 0;
        bit bad_ready = 0, bad_done = 0, bad_taps = 0;
        @(negedge clk);
        load_start = 1'b1;
        load_valid = junk_on_start;
        load_data  = W'(99);
        @(negedge clk);
        load_start = 1'b0;
        while (i < nwords && budget < 2000) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_data  = load_valid ? sent[i] : W'($urandom);
            if (load_ready !== 1'b1) bad_ready = 1;
            @(negedge clk);
            if (load_valid) i++;
            if (load_done !== (load_valid && i == nwords && nwords == LEN)) bad_done = 1;
            if (first_bad_tap() >= 0) bad_taps = 1;
            budget++;
        end
        load_valid = 1'b0;
        tests++;
        if (budget >= 2000) begin
            fails++;
            $display("[TB] FAIL load_timeout: accepted %0d words, required %0d", i, nwords);
        end
        tests++;
        if (bad_ready) begin
            fails++;
            $display("[TB] FAIL load_ready_high: load_ready was 0 during a load, required 1");
        end
        tests++;
        if (bad_done) begin
            fails++;
            $display("[TB] FAIL load_done_timing: pulse not exactly after word %0d", nwords);
        end
        tests++;
        if (bad_taps) begin
            fails++;
            $display("[TB] FAIL shadow_isolation: coeff_flat changed during a shadow load");
        end
        tests++;
        if (pending !== (nwords == LEN) || load_ready !== (nwords != LEN)) begin
            fails++;
            $display("[TB] FAIL post_load_state: pending=%0b load_ready=%0b, required pending=%0b",
                     pending, load_ready, nwords == LEN);
        end
        if (nwords == LEN) begin
            for (int k = 0; k < N; k++) shadow_m[k] = sent[word_for_tap(k)];
        end
    endtask

    // Holds swap_req without a tick for 'hold' cycles, then ticks once and checks the commit.
    task automatic do_swap(input int hold);
        bit bad = 0;
        int bt;
        swap_req    = 1'b1;
        sample_tick = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (pending !== 1'b1 || swap_done !== 1'b0 || first_bad_tap() >= 0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL swap_hold: state or taps changed without sample_tick");
        end
        sample_tick = 1'b1;
        @(negedge clk);
        swap_req    = 1'b0;
        sample_tick = 1'b0;
        for (int k = 0; k < N; k++) act_m[k] = shadow_m[k];
        bank_m = ~bank_m;
        tests++;
        if (swap_done !== 1'b1 || bank_sel !== bank_m || pending !== 1'b0) begin
            fails++;
            $display("[TB] FAIL swap_commit: swap_done=%0b bank_sel=%0b pending=%0b, required 1/%0b/0",
                     swap_done, bank_sel, pending, bank_m);
        end
        bt = first_bad_tap();
        tests++;
        if (bt >= 0) begin
            fails++;
            $display("[TB] FAIL swap_taps: tap %0d is %0d, required %0d",
                     bt, $signed(coeff_flat[bt*W +: W]), $signed(act_m[bt]));
        end
        @(negedge clk);
        tests++;
        if (swap_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL swap_done_pulse: still %0b a cycle later, required 0", swap_done);
        end
    endtask

    task automatic test_reset();
        int bt;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            act_m[k]    = '0;
            shadow_m[k] = '0;
        end
        bank_m = 1'b0;
        tests++;
        if ({load_ready, load_done, load_err, swap_done, pending, bank_sel} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b, required 000000",
                     {load_ready, load_done, load_err, swap_done, pending, bank_sel});
        end
        bt = first_bad_tap();
        tests++;
        if (bt >= 0) begin
            fails++;
            $display("[TB] FAIL reset_taps: tap %0d is %0d, required 0", bt, coeff_flat[bt*W +: W]);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) sent[i] = W'(i);
        load_words(LEN, 1'b0, 1'b0);
        do_swap(0);
    endtask

    task automatic test_hold();
        for (int i = 0; i < N; i++) sent[i] = W'(-5);
        load_words(LEN, 1'b1, 1'b0);
        do_swap(20);
    endtask

    task automatic test_restart();
        for (int i = 0; i < N; i++) sent[i] = W'($urandom_range(20, 120));
        load_words(30, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) sent[i] = W'(7);
        load_words(LEN, 1'b1, 1'b1);
        do_swap($urandom_range(0, 5));
    endtask

    task automatic test_err_idle();
        bit bad_ready;
        int bt;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = W'(9);
        bad_ready  = (load_ready !== 1'b0);
        @(negedge clk);
        load_valid = 1'b0;
        tests++;
        if (load_err !== 1'b1 || bad_ready) begin
            fails++;
            $display("[TB] FAIL err_pulse: load_err=%0b ready_bad=%0b, required 1/0", load_err, bad_ready);
        end
        @(negedge clk);
        tests++;
        if (load_err !== 1'b0 || load_ready !== 1'b0 || pending !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_after: load_err=%0b load_ready=%0b pending=%0b, required 0/0/0",
                     load_err, load_ready, pending);
        end
        bt = first_bad_tap();
        tests++;
        if (bt >= 0) begin
            fails++;
            $display("[TB] FAIL err_taps: tap %0d is %0d, required %0d", bt, coeff_flat[bt*W +: W], act_m[bt]);
        end
    endtask

    task automatic test_swap_wins();
        int bt;
        bit bad = 0;
        for (int i = 0; i < N; i++) sent[i] = W'($urandom);
        load_words(LEN, 1'b1, 1'b0);
        @(negedge clk);
        swap_req = 1'b1; sample_tick = 1'b1; load_start = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < N; k++) act_m[k] = shadow_m[k];
        bank_m = ~bank_m;
        tests++;
        if (swap_done !== 1'b1 || load_ready !== 1'b0 || pending !== 1'b0 || bank_sel !== bank_m) begin
            fails++;
            $display("[TB] FAIL swap_wins: swap_done=%0b load_ready=%0b pending=%0b bank_sel=%0b, required 1/0/0/%0b",
                     swap_done, load_ready, pending, bank_sel, bank_m);
        end
        bt = first_bad_tap();
        tests++;
        if (bt >= 0) begin
            fails++;
            $display("[TB] FAIL swap_wins_taps: tap %0d is %0d, required %0d", bt, coeff_flat[bt*W +: W], act_m[bt]);
        end
        // swap requests in IDLE must be ignored
        swap_req = 1'b1; sample_tick = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bank_sel !== bank_m || load_ready !== 1'b0 || first_bad_tap() >= 0) bad = 1;
            if (swap_done !== 1'b0 && bank_sel === bank_m) bad = 1;
        end
        idle_inputs();
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL swap_idle: bank_sel=%0b, required %0b with no swap", bank_sel, bank_m);
        end
    endtask

    task automatic test_pend_restart();
        for (int i = 0; i < N; i++) sent[i] = W'($urandom);
        load_words(LEN, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) sent[i] = W'($urandom);
        load_words(LEN, 1'b1, 1'b0);
        do_swap($urandom_range(0, 3));
    endtask

    task automatic test_reset_midload();
        bit bad = 0;
        int bt;
        for (int i = 0; i < N; i++) sent[i] = W'($urandom);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start  = 1'b0;
        swap_req    = 1'b1;
        sample_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = sent[i];
            @(negedge clk);
            if (swap_done !== 1'b0 || bank_sel !== bank_m) bad = 1;
        end
        idle_inputs();
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL swap_in_load: swap occurred during LOAD, bank_sel=%0b required %0b", bank_sel, bank_m);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            act_m[k]    = '0;
            shadow_m[k] = '0;
        end
        bank_m = 1'b0;
        tests++;
        if ({load_ready, pending, bank_sel, swap_done} !== 4'b0) begin
            fails++;
            $display("[TB] FAIL midload_reset: ready/pending/bank/swap=%b, required 0000",
                     {load_ready, pending, bank_sel, swap_done});
        end
        bt = first_bad_tap();
        tests++;
        if (bt >= 0) begin
            fails++;
            $display("[TB] FAIL midload_reset_taps: tap %0d is %0d, required 0", bt, coeff_flat[bt*W +: W]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) sent[i] = W'($urandom);
            load_words(LEN, 1'b1, 1'b0);
            do_swap($urandom_range(0, 8));
        end
    endtask

`ifdef COEFF_SYMMETRIC_EN
    task automatic test_symmetric();
        for (int i = 0; i < N; i++) sent[i] = W'(i + 1);
        load_words(36, 1'b0, 1'b0);
        do_swap(0);
        tests++;
        if (coeff_flat[0 +: W] !== W'(1) || coeff_flat[70*W +: W] !== W'(1) || coeff_flat[35*W +: W] !== W'(36)) begin
            fails++;
            $display("[TB] FAIL sym_taps: tap0=%0d tap70=%0d tap35=%0d, required 1/1/36",
                     coeff_flat[0 +: W], coeff_flat[70*W +: W], coeff_flat[35*W +: W]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_ramp();
        test_hold();
        test_restart();
        test_err_idle();
        test_swap_wins();
        test_pend_restart();
        test_reset_midload();
        test_random();
`ifdef COEFF_SYMMETRIC_EN
        test_symmetric();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
